// File: rtl/alu_exec_unit.sv
// Issue/writeback sequencer around an external 8-bit combinational alu.
// Three-cycle IDLE -> EXEC -> WB loop with a 4x8 register file and flags.
module alu_exec_unit #(
  parameter logic [7:0] REG_INIT   = 8'h00,
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [2:0]  ALU_OP,
  input  logic [7:0]  ALU_Y,
  input  logic        ALU_C,
  input  logic        ALU_V,
  input  logic        ALU_N,
  input  logic        ALU_Z,
  input  logic        HOST_WE,
  input  logic [1:0]  HOST_ADDR,
  input  logic [7:0]  HOST_WDATA,
  output logic [7:0]  HOST_RDATA,
  output logic [3:0]  FLAGS,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0][7:0] rf_q, rf_d;
  logic [3:0]      flags_q, flags_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      rd_q, rd_d;

  logic [2:0] i_op;
  logic [1:0] i_rd;
  logic [1:0] i_rs;
  logic       i_sel;
  logic [7:0] i_imm;

  assign i_op  = INSTR[15:13];
  assign i_rd  = INSTR[12:11];
  assign i_rs  = INSTR[10:9];
  assign i_sel = INSTR[8];
  assign i_imm = INSTR[7:0];

  always_comb begin
    state_d = state_q;
    rf_d    = rf_q;
    flags_d = flags_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;

    // host write first so a same-index writeback overrides it
    if (HOST_WE) rf_d[HOST_ADDR] = HOST_WDATA;

    unique case (state_q)
      IDLE: begin
        if (INSTR_VALID) begin
          rd_d    = i_rd;
          a_d     = rf_q[i_rd];
          b_d     = i_sel ? i_imm : rf_q[i_rs];
          op_d    = i_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rf_d[rd_q] = ALU_Y;
        flags_d    = {ALU_C, ALU_V, ALU_N, ALU_Z};
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      rf_q    <= {4{REG_INIT}};
      flags_q <= FLAGS_INIT;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'b000;
      rd_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      flags_q <= flags_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign INSTR_READY = (state_q == IDLE);
  assign BUSY        = (state_q != IDLE);
  assign DONE        = (state_q == WB);
  assign ALU_A       = a_q;
  assign ALU_B       = b_q;
  assign ALU_OP      = op_q;
  assign FLAGS       = flags_q;
  assign HOST_RDATA  = rf_q[HOST_ADDR];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: external alu model, register/flag reference
// model, directed scenarios then randomized instructions.
module tb_alu_exec_unit;

  logic        CLK;
  logic        RST_N;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  ALU_A, ALU_B;
  logic [2:0]  ALU_OP;
  logic [7:0]  ALU_Y;
  logic        ALU_C, ALU_V, ALU_N, ALU_Z;
  logic        HOST_WE;
  logic [1:0]  HOST_ADDR;
  logic [7:0]  HOST_WDATA;
  logic [7:0]  HOST_RDATA;
  logic [3:0]  FLAGS;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_r [4];
  logic [3:0] m_f;

  alu_exec_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP),
    .ALU_Y(ALU_Y), .ALU_C(ALU_C), .ALU_V(ALU_V),
    .ALU_N(ALU_N), .ALU_Z(ALU_Z),
    .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_RDATA(HOST_RDATA),
    .FLAGS(FLAGS), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // external alu: returns {C,V,N,Z,Y}
  function automatic logic [11:0] alu_fn(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    int ua, ub, sa, sb, s, ss;
    logic c, v;
    logic [7:0] y;
    ua = int'(a);
    ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    ss = 0;
    case (op)
      3'd0: begin
        s = ua + ub; ss = sa + sb;
        y = s[7:0]; c = (s > 255); v = (ss > 127) || (ss < -128);
      end
      3'd1: begin
        s = ua - ub; ss = sa - sb;
        y = s[7:0]; c = (ua < ub); v = (ss > 127) || (ss < -128);
      end
      3'd2:    y = a & b;
      3'd3:    y = a | b;
      3'd4:    y = a ^ b;
      3'd5:    y = a;
      3'd6:    y = b;
      default: y = ~a;
    endcase
    return {c, v, y[7], (y == 8'h00), y};
  endfunction

  assign {ALU_C, ALU_V, ALU_N, ALU_Z, ALU_Y} = alu_fn(ALU_OP, ALU_A, ALU_B);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx,
                           input logic [7:0] exp);
    HOST_ADDR = idx;
    #1;
    check(tag, HOST_RDATA, exp);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    HOST_WE = 1'b1; HOST_ADDR = a; HOST_WDATA = d;
    tick();
    HOST_WE = 1'b0;
    m_r[a] = d;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && !INSTR_READY; i++) tick();
    check("ready_wait", INSTR_READY, 1);
  endtask

  // ph: 0 no host write, 1 on the accept edge, 2 on the EXEC edge
  task automatic issue(input logic [15:0] w, input int ph,
                       input logic [1:0] ha, input logic [7:0] hd);
    logic [2:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  ea, eb;
    logic [11:0] res;
    op = w[15:13]; rd = w[12:11]; rs = w[10:9];
    wait_ready();
    ea = m_r[rd];
    eb = w[8] ? w[7:0] : m_r[rs];
    INSTR = w; INSTR_VALID = 1'b1;
    if (ph == 1) begin
      HOST_WE = 1'b1; HOST_ADDR = ha; HOST_WDATA = hd;
    end
    tick();
    INSTR_VALID = 1'b0; HOST_WE = 1'b0;
    if (ph == 1) m_r[ha] = hd;
    check("exec_busy", BUSY, 1);
    check("exec_ready", INSTR_READY, 0);
    check("alu_a", ALU_A, ea);
    check("alu_b", ALU_B, eb);
    check("alu_op", ALU_OP, op);
    res = alu_fn(op, ea, eb);
    if (ph == 2) begin
      HOST_WE = 1'b1; HOST_ADDR = ha; HOST_WDATA = hd;
    end
    tick();
    HOST_WE = 1'b0;
    if (ph == 2) m_r[ha] = hd;
    m_r[rd] = res[7:0];
    m_f = res[11:8];
    check("wb_done", DONE, 1);
    check("wb_flags", FLAGS, m_f);
    check_reg("wb_rd", rd, m_r[rd]);
    if (ph != 0) check_reg("wb_host", ha, m_r[ha]);
    tick();
    check("idle_ready", INSTR_READY, 1);
    check("idle_done", DONE, 0);
  endtask

  initial begin
    logic [15:0] w1, w2;
    logic [11:0] r1;
    logic        done_seen;
    RST_N = 1'b0; INSTR = '0; INSTR_VALID = 1'b0;
    HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_f = 4'b0000;

    repeat (2) tick();
    check("rst_ready", INSTR_READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_flags", FLAGS, 4'b0000);
    check("rst_alu_a", ALU_A, 8'h00);
    check("rst_alu_op", ALU_OP, 3'b000);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);
    RST_N = 1'b1;
    tick();

    // immediate add
    host_write(2'd1, 8'h3C);
    issue({3'b000, 2'd1, 2'd0, 1'b1, 8'h05}, 0, 2'd0, 8'h00);
    check_reg("imm_r1", 2'd1, 8'h41);
    check("imm_flags", FLAGS, 4'b0000);

    // carry and zero capture
    host_write(2'd0, 8'hFF);
    issue({3'b000, 2'd0, 2'd0, 1'b1, 8'h01}, 0, 2'd0, 8'h00);
    check("flag_cap", FLAGS, 4'b1001);
    check_reg("flag_r0", 2'd0, 8'h00);

    // writeback wins over same-index host write
    host_write(2'd2, 8'h50);
    issue({3'b000, 2'd2, 2'd0, 1'b1, 8'h05}, 2, 2'd2, 8'hAA);
    check_reg("coll_same", 2'd2, 8'h55);
    host_write(2'd2, 8'h50);
    issue({3'b000, 2'd2, 2'd0, 1'b1, 8'h05}, 2, 2'd3, 8'hAA);
    check_reg("coll_r2", 2'd2, 8'h55);
    check_reg("coll_r3", 2'd3, 8'hAA);

    // host write on accept edge; RD==RS reads same old value
    issue({3'b000, 2'd1, 2'd1, 1'b0, 8'h00}, 1, 2'd1, 8'h77);
    check_reg("acc_wr", 2'd1, 8'h82);

    // back-to-back with VALID held high
    w1 = {3'b000, 2'd1, 2'd0, 1'b1, 8'h10};
    w2 = {3'b000, 2'd2, 2'd1, 1'b0, 8'h00};
    r1 = alu_fn(3'b000, m_r[1], 8'h10);
    INSTR = w1; INSTR_VALID = 1'b1;
    tick();
    check("b2b_acc1", BUSY, 1);
    INSTR = w2;
    tick();
    check("b2b_wb1", DONE, 1);
    check("b2b_hold_a", ALU_B, 8'h10);
    tick();
    check("b2b_idle", INSTR_READY, 1);
    m_r[1] = r1[7:0];
    tick();
    INSTR_VALID = 1'b0;
    check("b2b_acc2", BUSY, 1);
    check("b2b_fwd", ALU_B, r1[7:0]);
    check("b2b_a2", ALU_A, m_r[2]);
    r1 = alu_fn(3'b000, m_r[2], m_r[1]);
    tick();
    m_r[2] = r1[7:0];
    m_f = r1[11:8];
    check("b2b_wb2", DONE, 1);
    check_reg("b2b_r2", 2'd2, m_r[2]);
    tick();

    // randomized
    for (int n = 0; n < 40; n++) begin
      issue(16'($urandom), int'($urandom_range(0, 2)),
            2'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) check_reg("rand_reg", 2'(i), m_r[i]);

    // reset mid-EXEC
    wait_ready();
    INSTR = {3'b000, 2'd3, 2'd3, 1'b1, 8'h01}; INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    check("mid_busy", BUSY, 1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_ready", INSTR_READY, 1);
    check("mid_rst_flags", FLAGS, 4'b0000);
    check("mid_rst_alu_a", ALU_A, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (DONE) done_seen = 1'b1;
    end
    check("mid_no_done", done_seen, 0);
    check("mid_busy0", BUSY, 0);
    for (int i = 0; i < 4; i++) check_reg("mid_reg", 2'(i), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequencing stage directly upstream and downstream of the 8-bit combinational alu.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from a 4-entry × 8-bit register file.
- Drives registered A/B/OP into the alu, then writes Y back to the register file and {C,V,N,Z} to a status register.
- Fixed 3-cycle issue interval; one instruction in flight at a time.

Parameters:
- REG_INIT, 8'h00, reset value of every register-file entry.
- FLAGS_INIT, 4'b0000, reset value of FLAGS {C,V,N,Z}.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- INSTR  input  16  {OP[15:13], RD[12:11], RS[10:9], IMM_SEL[8], IMM[7:0]}.
- INSTR_VALID  input  1  INSTR is valid.
- INSTR_READY  output  1  unit can accept INSTR this cycle.
- ALU_A  output  8  registered operand A to alu.
- ALU_B  output  8  registered operand B to alu.
- ALU_OP  output  3  registered opcode to alu.
- ALU_Y  input  8  alu result.
- ALU_C, ALU_V, ALU_N, ALU_Z  input  1 each  alu flags.
- HOST_WE  input  1  host register-file write strobe.
- HOST_ADDR  input  2  host write/read index.
- HOST_WDATA  input  8  host write data.
- HOST_RDATA  output  8  combinational R[HOST_ADDR].
- FLAGS  output  4  {C,V,N,Z} status register.
- BUSY  output  1  high when state is not IDLE.
- DONE  output  1  high for exactly the one cycle spent in WB.

Behaviour:
- Reset, asynchronous on RST_N low: state=IDLE, R[0..3]=REG_INIT, FLAGS=FLAGS_INIT, ALU_A=ALU_B=8'h00, ALU_OP=3'b000, latched RD=0. Resulting outputs: INSTR_READY=1, BUSY=0, DONE=0.
- FSM states: IDLE, EXEC, WB. Outputs: INSTR_READY = (state==IDLE); BUSY = (state!=IDLE); DONE = (state==WB).
- IDLE:
  - Edge with INSTR_VALID=1: latch RD, then ALU_A <= R[RD], ALU_B <= IMM_SEL ? IMM : R[RS], ALU_OP <= OP; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - alu settles combinationally from ALU_A/B/OP.
  - At the edge: R[RD] <= ALU_Y; FLAGS <= {ALU_C,ALU_V,ALU_N,ALU_Z}; go to WB.
- WB: DONE=1, INSTR_READY=0; at the edge go to IDLE unconditionally.
- Timing: handshake at edge k, result visible on HOST_RDATA and FLAGS after edge k+1, next accept no earlier than edge k+3.
- ALU_A, ALU_B and ALU_OP hold their values outside EXEC and change only on an IDLE accept.
- Operands are captured at the accept edge. A host write to R[RS] or R[RD] during EXEC does not change the operands of the in-flight instruction.
- RD==RS is legal: both operands read the same old value.
- HOST_WE is honoured in every state.
- If HOST_WE and the EXEC writeback target the same index on the same edge, the writeback wins and the host write is dropped. Different indices: both writes land.
- Host write on the accept edge: operands use the pre-write value.
- INSTR_VALID held high through EXEC/WB causes no extra accept. The word is accepted at the next IDLE edge.
- Reset asserted mid-EXEC or mid-WB aborts the instruction: no writeback, FLAGS returns to FLAGS_INIT, state returns to IDLE.
- 8-bit values pass through unmodified; the unit performs no arithmetic itself.

Test Plan:
- Reset then idle: RST_N low 2 cycles -> INSTR_READY=1, BUSY=0, FLAGS=0000, HOST_RDATA=00 for all four addresses.
- Immediate op: host writes R1=8'h3C; INSTR={3'b000,RD=1,RS=0,IMM_SEL=1,IMM=8'h05}; bench alu model returns Y=8'h41, flags 0000 -> ALU_A=3C, ALU_B=05 in EXEC; R1=41 and DONE=1 one cycle later; next INSTR_READY two cycles after accept.
- Flag capture: model returns Y=00, C=1, Z=1 -> FLAGS=4'b1001, R[RD]=00.
- Collision: HOST_WE to R2=AA on the EXEC edge of an instruction with RD=2, Y=55 -> R2=55. Repeat with HOST_ADDR=3 -> R2=55, R3=AA.
- Back-to-back: INSTR_VALID held high with two words, second word RS = first word's RD -> second accept exactly 3 cycles after the first, and ALU_B equals the first word's result.
- Reset mid-EXEC: RST_N pulsed low during EXEC -> R[RD] unchanged from REG_INIT, FLAGS=FLAGS_INIT, state IDLE, DONE never asserted.
